// File: rtl/carry_select_adder_pkg.sv
// Shared constants for the carry-select adder and its ripple-carry blocks.
package carry_select_adder_pkg;

  localparam int CSA_WIDTH = 16;
  localparam int CSA_BLK   = 4;

  // Number of carry-select blocks for a given operand width.
  function automatic int csa_nblk(input int width, input int blk);
    return width / blk;
  endfunction

endpackage

// File: rtl/carry_select_adder_rca_block.sv
// rca_block: W-bit ripple-carry adder built from per-bit full-adder equations.
module rca_block
  import carry_select_adder_pkg::*;
#(
  parameter int W = CSA_BLK
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry_s;

  // Full-adder chain; the carry is kept in one process so it ripples bit by bit.
  always_comb begin
    carry_s    = '0;
    sum        = '0;
    carry_s[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]         = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
    cout = carry_s[W];
  end

endmodule

// File: rtl/carry_select_adder.sv
// carry_select_adder: registered WIDTH-bit unsigned adder, {C,S} = A+B.
// Define CARRY_SELECT_ADDER_INREG_EN to add an input register stage (latency 2).
module carry_select_adder
  import carry_select_adder_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int BLK   = CSA_BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             C
);

  localparam int NBLK = csa_nblk(WIDTH, BLK);

  logic [WIDTH-1:0] a_op_s;
  logic [WIDTH-1:0] b_op_s;

`ifdef CARRY_SELECT_ADDER_INREG_EN
  logic [WIDTH-1:0] a_in_r;
  logic [WIDTH-1:0] b_in_r;

  // Input operand register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_in_r <= '0;
      b_in_r <= '0;
    end else begin
      a_in_r <= A;
      b_in_r <= B;
    end
  end

  assign a_op_s = a_in_r;
  assign b_op_s = b_in_r;
`else
  assign a_op_s = A;
  assign b_op_s = B;
`endif

  // Per-block candidate results for carry-in 0 and carry-in 1.
  logic [BLK-1:0] sum0_s [NBLK];
  logic [BLK-1:0] sum1_s [NBLK];
  logic           cout0_s [NBLK];
  logic           cout1_s [NBLK];

  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    rca_block #(.W(BLK)) u_rca0 (
      .a    (a_op_s[g*BLK +: BLK]),
      .b    (b_op_s[g*BLK +: BLK]),
      .cin  (1'b0),
      .sum  (sum0_s[g]),
      .cout (cout0_s[g])
    );
    if (g == 0) begin : g_first
      // Block 0 always sees carry-in 0, so both candidates are the same adder.
      assign sum1_s[g]  = sum0_s[g];
      assign cout1_s[g] = cout0_s[g];
    end else begin : g_rest
      rca_block #(.W(BLK)) u_rca1 (
        .a    (a_op_s[g*BLK +: BLK]),
        .b    (b_op_s[g*BLK +: BLK]),
        .cin  (1'b1),
        .sum  (sum1_s[g]),
        .cout (cout1_s[g])
      );
    end
  end

  logic [WIDTH-1:0] sum_s;
  logic             carry_s;

  // Select chain: each block's carry-out picks the next block's candidate.
  always_comb begin
    sum_s   = '0;
    carry_s = 1'b0;
    for (int i = 0; i < NBLK; i++) begin
      if (carry_s) begin
        sum_s[i*BLK +: BLK] = sum1_s[i];
        carry_s             = cout1_s[i];
      end else begin
        sum_s[i*BLK +: BLK] = sum0_s[i];
        carry_s             = cout0_s[i];
      end
    end
  end

  logic [WIDTH-1:0] s_r;
  logic             c_r;

  // Output result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_r <= '0;
      c_r <= 1'b0;
    end else begin
      s_r <= sum_s;
      c_r <= carry_s;
    end
  end

  assign S = s_r;
  assign C = c_r;

endmodule

// File: tb/tb_carry_select_adder.sv
// Scoreboard bench for carry_select_adder; honours CARRY_SELECT_ADDER_INREG_EN latency.
module tb_carry_select_adder;

  localparam int W = 16;
`ifdef CARRY_SELECT_ADDER_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] A     = '0;
  logic [W-1:0] B     = '0;
  logic [W-1:0] S;
  logic         C;

  carry_select_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .S     (S),
    .C     (C)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         due;
    logic [W:0] exp;
    string      name;
  } item_t;

  item_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got C,S=%h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every result whose due cycle has been reached.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      item_t it;
      it = q.pop_front();
      check(it.name, {C, S}, it.exp);
    end
  end

  task automatic drive(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W:0] exp);
    @(negedge clk);
    A = a;
    B = b;
    q.push_back('{cyc + LAT, exp, name});
  endtask

  // Release reset together with a new operand pair.
  task automatic release_with(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W:0] exp);
    @(negedge clk);
    rst_n = 1'b1;
    A = a;
    B = b;
    for (int k = 1; k < LAT; k++) q.push_back('{cyc + k, 17'h0_0000, "post_rst_fill"});
    q.push_back('{cyc + LAT, exp, name});
  endtask

  logic [W-1:0] da [10] = '{16'h4B37, 16'hFFFF, 16'h8000, 16'h000F, 16'h00F0,
                            16'hFFFF, 16'h0000, 16'h0F0F, 16'h1234, 16'h1234};
  logic [W-1:0] db [10] = '{16'h243B, 16'h0001, 16'h8000, 16'h0001, 16'h0010,
                            16'hFFFF, 16'h0000, 16'hF0F1, 16'h4321, 16'h4321};
  logic [W:0]   de [10] = '{17'h0_6F72, 17'h1_0000, 17'h1_0000, 17'h0_0010, 17'h0_0100,
                            17'h1_FFFE, 17'h0_0000, 17'h1_0000, 17'h0_5555, 17'h0_5555};

  initial begin
    A     = 16'hFFFF;
    B     = 16'hFFFF;
    rst_n = 1'b0;
    #2;
    check("rst_async", {C, S}, 17'h0_0000);
    @(posedge clk);
    #1;
    check("rst_hold", {C, S}, 17'h0_0000);
    repeat (2) @(posedge clk);

    release_with("first_after_rst", 16'h7533, 16'h2A67, 17'h0_9F9A);

    for (int i = 0; i < 10; i++) drive($sformatf("dir%0d", i), da[i], db[i], de[i]);

    // Reset in the middle of a stream: the in-flight result must vanish.
    drive("pre_rst", 16'h1234, 16'h1111, 17'h0_2345);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("rst_midstream", {C, S}, 17'h0_0000);
    @(posedge clk);
    #1;
    check("rst_mid_hold", {C, S}, 17'h0_0000);
    release_with("after_mid_rst", 16'h0102, 16'h0203, 17'h0_0305);

    for (int i = 0; i < 10000; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      drive("rand", ra, rb, {1'b0, ra} + {1'b0, rb});
    end

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending results expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
